// File: rtl/ksa_out_skid.sv
// ksa_out_skid
// Output register stage for the 32-bit Kogge-Stone adder datapath. It captures
// the adder sum and carry-out and hands them downstream over valid/ready.
// A 2-entry skid buffer (main + skid) keeps one result per cycle flowing under
// backpressure, and in_ready is a registered flag with no combinational path
// from out_ready. res_cnt counts delivered results and wraps around.
//
// Optional feature: define KSA_OUT_OVF_EN to compute and carry a signed
// overflow flag with each entry. Without it, ovf_q is tied to 0 and the
// port list does not change.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   in_valid   adder result valid this cycle
//   in_ready   stage can accept a result (registered)
//   sum_d      adder sum
//   cout_d     adder carry-out
//   a_msb      MSB of operand A (overflow calc)
//   b_msb      MSB of operand B (overflow calc)
//   out_valid  registered result valid
//   out_ready  downstream accepts result
//   sum_q      registered sum (main entry)
//   cout_q     registered carry-out (main entry)
//   ovf_q      registered signed-overflow flag (main entry)
//   res_cnt    count of delivered results
//
// state | meaning
// ------+----------------------------------
// EMPTY | no data held, out_valid=0
// ONE   | main entry valid
// FULL  | main and skid entries valid, in_ready=0

module ksa_out_skid #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] sum_d,
   input  logic                  cout_d,
   input  logic                  a_msb,
   input  logic                  b_msb,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] sum_q,
   output logic                  cout_q,
   output logic                  ovf_q,
   output logic [CNT_WIDTH-1:0]  res_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t                state_q;
   logic                  in_ready_q;
   logic [DATA_WIDTH-1:0] skid_sum_q;
   logic                  skid_cout_q;
   logic [CNT_WIDTH-1:0]  res_cnt_q;

   logic acc;
   logic dlv;
   logic ld_main_in;
   logic ld_skid;
   logic ld_main_skid;

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != ST_EMPTY);
   assign res_cnt   = res_cnt_q;

   assign acc = in_valid & in_ready_q;
   assign dlv = out_valid & out_ready;

   // Storage strobes. In ONE an accept with a simultaneous delivery goes
   // straight into main; only an accept without delivery spills into skid.
   assign ld_main_in   = acc & ((state_q == ST_EMPTY) | ((state_q == ST_ONE) & dlv));
   assign ld_skid      = acc & (state_q == ST_ONE) & ~dlv;
   assign ld_main_skid = dlv & (state_q == ST_FULL);

   // Control FSM; in_ready is loaded from the next state so it is registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               in_ready_q <= 1'b1;
               if (acc) begin
                  state_q <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (acc && !dlv) begin
                  state_q    <= ST_FULL;
                  in_ready_q <= 1'b0;
               end else if (!acc && dlv) begin
                  state_q    <= ST_EMPTY;
                  in_ready_q <= 1'b1;
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            ST_FULL: begin
               if (dlv) begin
                  state_q    <= ST_ONE;
                  in_ready_q <= 1'b1;
               end else begin
                  in_ready_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= ST_EMPTY;
               in_ready_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_q       <= '0;
         cout_q      <= 1'b0;
         skid_sum_q  <= '0;
         skid_cout_q <= 1'b0;
      end else begin
         if (ld_main_in) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
         end else if (ld_main_skid) begin
            sum_q  <= skid_sum_q;
            cout_q <= skid_cout_q;
         end
         if (ld_skid) begin
            skid_sum_q  <= sum_d;
            skid_cout_q <= cout_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_cnt_q <= '0;
      end else if (dlv) begin
         res_cnt_q <= res_cnt_q + CNT_WIDTH'(1);
      end
   end

`ifdef KSA_OUT_OVF_EN
   // Signed overflow: operands agree in sign but the sum does not.
   logic ovf_in;
   logic skid_ovf_q;

   assign ovf_in = (a_msb == b_msb) & (sum_d[DATA_WIDTH-1] != a_msb);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_q      <= 1'b0;
         skid_ovf_q <= 1'b0;
      end else begin
         if (ld_main_in) begin
            ovf_q <= ovf_in;
         end else if (ld_main_skid) begin
            ovf_q <= skid_ovf_q;
         end
         if (ld_skid) begin
            skid_ovf_q <= ovf_in;
         end
      end
   end
`else
   // Operand MSBs only matter for the overflow flag.
   logic unused_msb;
   assign unused_msb = a_msb ^ b_msb;
   assign ovf_q      = 1'b0;
`endif

endmodule

// File: doc/ksa_out_skid.md
# ksa_out_skid

Output-side register stage for the 32-bit Kogge-Stone adder datapath. Captures the adder's combinational sum and carry-out, and presents them downstream through a valid/ready handshake. A 2-entry skid buffer provides full throughput under backpressure. Also keeps a wrap-around count of delivered results. It mirrors the input capture register at the other end of the adder.

## Interface
- DATA_WIDTH, 32, width of sum operand/result
- CNT_WIDTH, 16, width of delivered-result counter
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  adder result valid this cycle
- in_ready  out  1  stage can accept a result
- sum_d  in  DATA_WIDTH  adder sum
- cout_d  in  1  adder carry-out
- a_msb  in  1  MSB of operand A feeding the adder (overflow calc)
- b_msb  in  1  MSB of operand B feeding the adder (overflow calc)
- out_valid  out  1  registered result valid
- out_ready  in  1  downstream accepts result
- sum_q  out  DATA_WIDTH  registered sum
- cout_q  out  1  registered carry-out
- ovf_q  out  1  registered signed-overflow flag (see Configuration)
- res_cnt  out  CNT_WIDTH  count of delivered results

## Operation
- Accept: acc = in_valid & in_ready. Deliver: dlv = out_valid & out_ready.
- Storage:
  - main entry {sum, cout, ovf} drives sum_q/cout_q/ovf_q.
  - skid entry holds one overflow result.
- States: EMPTY (no data), ONE (main valid), FULL (main + skid valid).
- EMPTY:
  - acc -> ONE; main <= input.
- ONE:
  - acc & dlv -> ONE; main <= input.
  - acc & !dlv -> FULL; skid <= input.
  - !acc & dlv -> EMPTY.
  - otherwise hold.
- FULL:
  - dlv -> ONE; main <= skid.
  - otherwise hold.
- Outputs:
  - out_valid = (state != EMPTY).
  - in_ready = registered flag: 1 in EMPTY/ONE, 0 in FULL, per next-state.
- res_cnt increments by 1 on every dlv. It wraps from 2^CNT_WIDTH-1 to 0.
- Data is never dropped or duplicated. A held main entry keeps sum_q/cout_q/ovf_q stable while out_valid=1 & out_ready=0.
- Arithmetic: pure pass-through; sum_q/cout_q bit-identical to captured inputs.

## Timing
- Reset (rst=0), asynchronous:
  - state=EMPTY, in_ready=0, out_valid=0.
  - sum_q=0, cout_q=0, ovf_q=0, res_cnt=0.
  - skid cleared.
- in_ready rises on first rising clk edge after rst deasserts.
- Latency: acc at edge N -> out_valid=1 with data after edge N (visible cycle N+1).
- Throughput: 1 result/cycle while out_ready=1.
- in_ready is registered (no combinational path out_ready -> in_ready). It falls the cycle after the FULL transition and rises the cycle after FULL drains.
- Simultaneous acc & dlv in ONE: new data replaces main; res_cnt increments; state unchanged.
- Reset mid-operation: contents discarded immediately; no partial delivery; res_cnt to 0.

## Configuration
- Macro KSA_OUT_OVF_EN:
  - Defined: ovf computed at accept as (a_msb == b_msb) & (sum_d[DATA_WIDTH-1] != a_msb). It is stored with the entry and travels through skid/main like data.
  - Undefined: no ovf storage; ovf_q tied 0. Port list unchanged.

## Test plan
- Reset release:
  - during rst=0, all outputs 0.
  - after first edge, in_ready=1, out_valid=0, res_cnt=0.
- Single transfer, out_ready=1:
  - sum_d=0x0000_0005, cout_d=0, in_valid for one cycle.
  - Next cycle out_valid=1, sum_q=0x0000_0005; then out_valid=0; res_cnt=1.
- Backpressure:
  - out_ready=0; send 0x11, 0x22, 0x33 back-to-back.
  - 0x11 in main, 0x22 in skid, in_ready=0, 0x33 held by source.
  - Release out_ready: delivered order 0x11, 0x22, 0x33; res_cnt=3.
- Overflow, with KSA_OUT_OVF_EN:
  - a_msb=0, b_msb=0, sum_d=0x8000_0000 -> ovf_q=1.
  - a_msb=1, b_msb=0, same sum -> ovf_q=0.
  - Without macro, ovf_q=0 always.
- Counter wrap:
  - CNT_WIDTH=4; stream 17 results with out_ready=1 -> res_cnt reads 1.
- Reset mid-FULL:
  - Assert rst with both entries valid -> out_valid=0, sum_q=0 immediately.
  - After release, no stale data delivered.
